// File: rtl/xadc_drp_scanner.sv
// ---------------------------------------------------------------------------
// xadc_drp_scanner
//
// Table-driven DRP polling engine for the 7-series XADC hard block.
// After reset it performs a read-modify-write of Config Register 0 (DRP 0x40)
// to clear the averaging bits. It then reads every address in ADDR_LIST once
// per XADC end-of-sequence. Each captured word updates a per-slot hysteresis
// alarm. A DRDY watchdog abandons stuck transactions and raises a sticky
// error flag.
//
// Parameters
//   NCH        number of DRP addresses scanned per pass (1..32)
//   ADDR_LIST  NCH x 7 bits, slot i at [7i+6:7i], slot 0 scanned first
//   CFG0_MASK  AND mask applied to the Config Register 0 value during init
//   HI_LIMIT   NCH x 16 bits, alarm set threshold (word > limit sets)
//   LO_LIMIT   NCH x 16 bits, alarm clear threshold (word < limit clears)
//   TIMEOUT    maximum wait cycles for DRDY (8-bit counter)
//
// Ports
//   I_sys_clk    clock, also drives the XADC DCLK
//   I_rst_n      synchronous active-low reset
//   I_enable     scan enable, only looked at while waiting for EOS
//   I_busy       XADC BUSY, holds off the init read
//   I_eos        XADC end-of-sequence pulse
//   I_drdy       XADC DRDY
//   I_do         XADC DO
//   O_daddr      DRP address
//   O_den        DRP enable, one-cycle pulse per transaction
//   O_dwe        DRP write enable, high together with O_den on writes only
//   O_di         DRP write data
//   O_data       last captured word per slot, slot i at [16i+15:16i]
//   O_upd        one-cycle strobe, bit i set when slot i was just written
//   O_alarm      hysteresis alarm per slot
//   O_scan_done  one-cycle pulse after the last slot of a pass
//   O_scan_cnt   completed passes, wraps 0xFFFF -> 0
//   O_err        sticky DRDY timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module xadc_drp_scanner #(
  parameter int                NCH       = 8,
  parameter logic [NCH*7-1:0]  ADDR_LIST = {7'h27, 7'h26, 7'h25, 7'h24,
                                            7'h06, 7'h02, 7'h01, 7'h00},
  parameter logic [15:0]       CFG0_MASK = 16'h03FF,
  parameter logic [NCH*16-1:0] HI_LIMIT  = {NCH{16'hFFFF}},
  parameter logic [NCH*16-1:0] LO_LIMIT  = {NCH{16'h0000}},
  parameter int                TIMEOUT   = 255
) (
  input  logic              I_sys_clk,
  input  logic              I_rst_n,
  input  logic              I_enable,
  input  logic              I_busy,
  input  logic              I_eos,
  input  logic              I_drdy,
  input  logic [15:0]       I_do,
  output logic [6:0]        O_daddr,
  output logic              O_den,
  output logic              O_dwe,
  output logic [15:0]       O_di,
  output logic [NCH*16-1:0] O_data,
  output logic [NCH-1:0]    O_upd,
  output logic [NCH-1:0]    O_alarm,
  output logic              O_scan_done,
  output logic [15:0]       O_scan_cnt,
  output logic              O_err
);

  localparam int             SW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0]  LAST_SLOT = SW'(NCH - 1);
  localparam logic [7:0]     TMO       = 8'(TIMEOUT);
  localparam logic [6:0]     CFG0_ADDR = 7'h40;

  typedef enum logic [2:0] {
    INIT_RD,
    INIT_RWAIT,
    INIT_WR,
    INIT_WWAIT,
    WAIT_EOS,
    RD,
    RD_WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] slot;
  logic [7:0]    tcnt;

  logic [6:0]    slot_addr;
  logic [15:0]   slot_hi;
  logic [15:0]   slot_lo;
  logic          timed_out;
  logic          last_slot;

  // Per-slot table lookups for the slot currently being scanned.
  always_comb begin
    slot_addr = ADDR_LIST[int'(slot)*7 +: 7];
    slot_hi   = HI_LIMIT[int'(slot)*16 +: 16];
    slot_lo   = LO_LIMIT[int'(slot)*16 +: 16];
    timed_out = (tcnt == TMO);
    last_slot = (slot == LAST_SLOT);
  end

  // Scan sequencer. Every *_WAIT state is entered from a den cycle, which
  // also clears the watchdog, so the counter measures wait cycles only.
  // DRDY is only looked at in the *_WAIT states; anything arriving elsewhere
  // (e.g. a response left over from before a reset) is ignored.
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      state       <= INIT_RD;
      slot        <= '0;
      tcnt        <= '0;
      O_daddr     <= '0;
      O_den       <= 1'b0;
      O_dwe       <= 1'b0;
      O_di        <= '0;
      O_data      <= '0;
      O_upd       <= '0;
      O_alarm     <= '0;
      O_scan_done <= 1'b0;
      O_scan_cnt  <= '0;
      O_err       <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      O_den       <= 1'b0;
      O_dwe       <= 1'b0;
      O_upd       <= '0;
      O_scan_done <= 1'b0;

      case (state)
        // Read Config Register 0 once the XADC is not busy.
        INIT_RD: begin
          if (!I_busy) begin
            O_daddr <= CFG0_ADDR;
            O_den   <= 1'b1;
            tcnt    <= '0;
            state   <= INIT_RWAIT;
          end
        end

        // Masked value becomes the write data. On timeout the write is
        // skipped so the configuration is left exactly as it was.
        INIT_RWAIT: begin
          if (I_drdy) begin
            O_di  <= I_do & CFG0_MASK;
            state <= INIT_WR;
          end else if (timed_out) begin
            O_err <= 1'b1;
            state <= WAIT_EOS;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        INIT_WR: begin
          O_daddr <= CFG0_ADDR;
          O_den   <= 1'b1;
          O_dwe   <= 1'b1;
          tcnt    <= '0;
          state   <= INIT_WWAIT;
        end

        INIT_WWAIT: begin
          if (I_drdy) begin
            state <= WAIT_EOS;
          end else if (timed_out) begin
            O_err <= 1'b1;
            state <= WAIT_EOS;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        // EOS is only honoured here; pulses during a pass are dropped.
        WAIT_EOS: begin
          if (I_eos && I_enable) begin
            slot  <= '0;
            state <= RD;
          end
        end

        RD: begin
          O_daddr <= slot_addr;
          O_den   <= 1'b1;
          tcnt    <= '0;
          state   <= RD_WAIT;
        end

        // A timed-out slot keeps its old word and alarm but the pass still
        // moves on, so one dead register cannot stall the whole scan.
        RD_WAIT: begin
          if (I_drdy || timed_out) begin
            if (I_drdy) begin
              O_data[int'(slot)*16 +: 16] <= I_do;
              O_upd[slot]                 <= 1'b1;
              if (I_do > slot_hi) begin
                O_alarm[slot] <= 1'b1;
              end else if (I_do < slot_lo) begin
                O_alarm[slot] <= 1'b0;
              end
            end else begin
              O_err <= 1'b1;
            end
            if (last_slot) begin
              state <= DONE;
            end else begin
              slot  <= slot + 1'b1;
              state <= RD;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        DONE: begin
          O_scan_done <= 1'b1;
          O_scan_cnt  <= O_scan_cnt + 16'd1;
          state       <= WAIT_EOS;
        end

        default: state <= INIT_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// ---------------------------------------------------------------------------
// tb_xadc_drp_scanner
//
// Self-checking bench for xadc_drp_scanner. A DRP responder stands in for
// the XADC. Stimulus pushes the expected DRP requests, slot updates and
// pass completions into a scoreboard queue. A monitor pops and compares
// whenever the DUT shows den, upd or scan_done. Expected values come from a
// small pass-level model of the scan rules.
// ---------------------------------------------------------------------------
module tb_xadc_drp_scanner;

  localparam int NCH     = 8;
  localparam int TIMEOUT = 255;

  localparam logic [NCH*7-1:0]  ADDR_P = {7'h27, 7'h26, 7'h25, 7'h24,
                                          7'h06, 7'h02, 7'h01, 7'h00};
  localparam logic [NCH*16-1:0] HI_P   = {16'hF000, 16'hE000, 16'hC000, 16'hA000,
                                          16'h9000, 16'h4000, 16'hA000, 16'h8000};
  localparam logic [NCH*16-1:0] LO_P   = {16'h1000, 16'h2000, 16'h4000, 16'h8000,
                                          16'h0800, 16'h2000, 16'h6000, 16'h7000};

  // Reference tables, listed slot 0 first.
  localparam logic [6:0]  SCAN_ADDR [NCH] = '{7'h00, 7'h01, 7'h02, 7'h06,
                                              7'h24, 7'h25, 7'h26, 7'h27};
  localparam logic [15:0] HI_M [NCH] = '{16'h8000, 16'hA000, 16'h4000, 16'h9000,
                                         16'hA000, 16'hC000, 16'hE000, 16'hF000};
  localparam logic [15:0] LO_M [NCH] = '{16'h7000, 16'h6000, 16'h2000, 16'h0800,
                                         16'h8000, 16'h4000, 16'h2000, 16'h1000};

  logic              clock;
  logic              rst_n;
  logic              enable;
  logic              busy;
  logic              eos;
  logic              drdy;
  logic [15:0]       drp_do;
  logic [6:0]        daddr;
  logic              den;
  logic              dwe;
  logic [15:0]       di;
  logic [NCH*16-1:0] data;
  logic [NCH-1:0]    upd;
  logic [NCH-1:0]    alarm;
  logic              scan_done;
  logic [15:0]       scan_cnt;
  logic              err;

  xadc_drp_scanner #(
    .NCH       (NCH),
    .ADDR_LIST (ADDR_P),
    .CFG0_MASK (16'h03FF),
    .HI_LIMIT  (HI_P),
    .LO_LIMIT  (LO_P),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .I_sys_clk   (clock),
    .I_rst_n     (rst_n),
    .I_enable    (enable),
    .I_busy      (busy),
    .I_eos       (eos),
    .I_drdy      (drdy),
    .I_do        (drp_do),
    .O_daddr     (daddr),
    .O_den       (den),
    .O_dwe       (dwe),
    .O_di        (di),
    .O_data      (data),
    .O_upd       (upd),
    .O_alarm     (alarm),
    .O_scan_done (scan_done),
    .O_scan_cnt  (scan_cnt),
    .O_err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // DRP responder state
  logic [15:0] mem [128];
  int          lat;
  bit          withhold_on;
  logic [6:0]  withhold_addr;
  logic [6:0]  resp_addr;
  logic        resp_we;
  int          resp_k;

  // Scoreboard
  typedef enum int {EV_DEN, EV_UPD, EV_DONE} ev_e;
  typedef struct {
    ev_e               kind;
    logic [6:0]        addr;
    logic              we;
    logic [15:0]       di;
    logic              err;
    int                gap;
    int                slot;
    logic [NCH-1:0]    upd;
    logic [15:0]       word;
    logic [NCH-1:0]    alarm;
    logic [15:0]       cnt;
    logic [NCH*16-1:0] data;
  } item_t;
  item_t sb[$];

  // Pass-level reference model
  logic [15:0]    data_m [NCH];
  logic [NCH-1:0] alarm_m;
  logic [15:0]    cnt_m;
  logic           err_m;

  // Monitor state
  int  cyc;
  int  last_den;
  bit  prev_den;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic item_t new_item(input ev_e k);
    item_t it;
    it.kind  = k;
    it.addr  = '0;
    it.we    = 1'b0;
    it.di    = '0;
    it.err   = 1'b0;
    it.gap   = 0;
    it.slot  = 0;
    it.upd   = '0;
    it.word  = '0;
    it.alarm = '0;
    it.cnt   = '0;
    it.data  = '0;
    return it;
  endfunction

  function automatic logic [NCH*16-1:0] pack_model();
    logic [NCH*16-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*16 +: 16] = data_m[i];
    return v;
  endfunction

  task automatic push_den(input logic [6:0] a, input logic w, input logic [15:0] d,
                          input int gap);
    item_t it;
    it      = new_item(EV_DEN);
    it.addr = a;
    it.we   = w;
    it.di   = d;
    it.err  = err_m;
    it.gap  = gap;
    sb.push_back(it);
  endtask

  // Expected outcome of one full pass given the current responder memory.
  task automatic push_pass();
    int          gap;
    logic [15:0] w;
    item_t       it;
    gap = 0;
    for (int i = 0; i < NCH; i++) begin
      push_den(SCAN_ADDR[i], 1'b0, 16'h0000, gap);
      gap = 0;
      if (withhold_on && SCAN_ADDR[i] == withhold_addr) begin
        err_m = 1'b1;
        gap   = TIMEOUT + 2;
      end else begin
        w         = mem[SCAN_ADDR[i]];
        data_m[i] = w;
        if (w > HI_M[i])      alarm_m[i] = 1'b1;
        else if (w < LO_M[i]) alarm_m[i] = 1'b0;
        it       = new_item(EV_UPD);
        it.slot  = i;
        it.upd   = '0;
        it.upd[i] = 1'b1;
        it.word  = w;
        it.alarm = alarm_m;
        sb.push_back(it);
      end
    end
    cnt_m    = cnt_m + 16'd1;
    it       = new_item(EV_DONE);
    it.cnt   = cnt_m;
    it.data  = pack_model();
    it.alarm = alarm_m;
    it.err   = err_m;
    sb.push_back(it);
  endtask

  task automatic take(input ev_e kind, output item_t it, output bit ok);
    compared++;
    ok = 1'b0;
    it = new_item(kind);
    if (sb.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      it = sb.pop_front();
      if (it.kind != kind) begin
        mismatched++;
        $display("[TB] FAIL event_order: got kind %0d, expected kind %0d", kind, it.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // DRP responder: answers each den after 'lat' cycles, writes update the
  // memory, a withheld read address never answers, reset abandons a reply.
  initial begin
    drdy   = 1'b0;
    drp_do = 16'h0000;
    forever begin
      @(negedge clock);
      if (rst_n && den) begin
        resp_addr = daddr;
        resp_we   = dwe;
        if (resp_we) mem[resp_addr] = di;
        if (!(withhold_on && !resp_we && resp_addr == withhold_addr)) begin
          resp_k = 0;
          while (resp_k < lat && rst_n) begin
            @(negedge clock);
            resp_k++;
          end
          if (rst_n) begin
            drdy   = 1'b1;
            drp_do = resp_we ? 16'h0000 : mem[resp_addr];
            @(negedge clock);
            drdy   = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard.
  initial begin
    item_t it;
    bit    ok;
    cyc      = 0;
    last_den = 0;
    prev_den = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (rst_n) begin
        if (dwe) checkOutput("dwe_only_with_den", 128'(den), 128'(1));
        if (upd != '0) begin
          take(EV_UPD, it, ok);
          if (ok) begin
            checkOutput("upd_strobe", 128'(upd), 128'(it.upd));
            checkOutput("captured_word", 128'(data[it.slot*16 +: 16]), 128'(it.word));
            checkOutput("alarm_on_upd", 128'(alarm), 128'(it.alarm));
          end
        end
        if (scan_done) begin
          take(EV_DONE, it, ok);
          if (ok) begin
            checkOutput("scan_cnt", 128'(scan_cnt), 128'(it.cnt));
            checkOutput("data_after_pass", 128'(data), 128'(it.data));
            checkOutput("alarm_after_pass", 128'(alarm), 128'(it.alarm));
            checkOutput("err_after_pass", 128'(err), 128'(it.err));
          end
        end
        if (den) begin
          checkOutput("den_single_cycle", 128'(prev_den), 128'(0));
          take(EV_DEN, it, ok);
          if (ok) begin
            checkOutput("den_addr", 128'(daddr), 128'(it.addr));
            checkOutput("den_we", 128'(dwe), 128'(it.we));
            if (it.we) checkOutput("write_data", 128'(di), 128'(it.di));
            checkOutput("err_at_den", 128'(err), 128'(it.err));
            if (it.gap > 0) checkOutput("timeout_gap", 128'(cyc - last_den), 128'(it.gap));
          end
          last_den = cyc;
        end
      end
      prev_den = den;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < NCH; i++) mem[SCAN_ADDR[i]] = 16'($urandom);
    lat = int'($urandom_range(1, 5));
  endtask

  // One EOS pulse; when a pass is expected its outcome is queued first.
  task automatic applyStimulus(input logic en, input bit expect_pass);
    @(negedge clock);
    enable = en;
    if (expect_pass) push_pass();
    eos = 1'b1;
    @(negedge clock);
    eos = 1'b0;
  endtask

  // Reset, check reset values, then queue the init read-modify-write.
  task automatic reset_dut();
    @(negedge clock);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    sb.delete();
    for (int i = 0; i < NCH; i++) data_m[i] = 16'h0000;
    alarm_m = '0;
    cnt_m   = '0;
    err_m   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_daddr", 128'(daddr), 128'(0));
    checkOutput("rst_den", 128'(den), 128'(0));
    checkOutput("rst_dwe", 128'(dwe), 128'(0));
    checkOutput("rst_di", 128'(di), 128'(0));
    checkOutput("rst_data", 128'(data), 128'(0));
    checkOutput("rst_upd", 128'(upd), 128'(0));
    checkOutput("rst_alarm", 128'(alarm), 128'(0));
    checkOutput("rst_scan_done", 128'(scan_done), 128'(0));
    checkOutput("rst_scan_cnt", 128'(scan_cnt), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    push_den(7'h40, 1'b0, 16'h0000, 0);
    push_den(7'h40, 1'b1, mem[7'h40] & 16'h03FF, 0);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  logic [15:0] hyst_words [6] = '{16'h8001, 16'h7800, 16'h6FFF, 16'h8000, 16'h8001, 16'h7000};
  logic        hyst_alarm [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int          dens;

  initial begin
    rst_n         = 1'b0;
    busy          = 1'b1;
    enable        = 1'b0;
    eos           = 1'b0;
    lat           = 3;
    withhold_on   = 1'b0;
    withhold_addr = 7'h00;
    for (int a = 0; a < 128; a++) mem[a] = 16'(a) * 16'h0101;
    mem[7'h40] = 16'h93A5;

    // Init RMW, held off by BUSY; no reads before the first EOS.
    reset_dut();
    repeat (6) begin
      @(negedge clock);
      checkOutput("den_held_while_busy", 128'(den), 128'(0));
    end
    busy = 1'b0;
    wait_drain(300);
    idle(20);
    checkOutput("cfg0_written", 128'(mem[7'h40]), 128'(16'h03A5));
    applyStimulus(1'b0, 1'b0);
    idle(30);

    // Ordered pattern pass: word = addr * 0x0101.
    $display("[TB] scan order and capture");
    lat = 3;
    applyStimulus(1'b1, 1'b1);
    wait_drain(500);
    checkOutput("slot3_word", 128'(data[63:48]), 128'(16'h0606));
    checkOutput("scan_cnt_first_pass", 128'(scan_cnt), 128'(1));

    // DRDY withheld for slot 2.
    $display("[TB] drdy timeout on slot 2");
    fill_mem_random();
    withhold_on   = 1'b1;
    withhold_addr = 7'h02;
    applyStimulus(1'b1, 1'b1);
    wait_drain(2000);
    withhold_on = 1'b0;
    checkOutput("err_sticky", 128'(err), 128'(1));
    checkOutput("slot2_kept", 128'(data[47:32]), 128'(16'h0202));

    // Hysteresis on slot 0, including both exact-limit words.
    $display("[TB] hysteresis on slot 0");
    for (int j = 0; j < 6; j++) begin
      fill_mem_random();
      mem[7'h00] = hyst_words[j];
      applyStimulus(1'b1, 1'b1);
      wait_drain(500);
      checkOutput("alarm0_hysteresis", 128'(alarm[0]), 128'(hyst_alarm[j]));
    end

    // Random passes.
    $display("[TB] random passes");
    repeat (6) begin
      fill_mem_random();
      applyStimulus(1'b1, 1'b1);
      wait_drain(500);
    end

    // Enable dropped mid-pass: pass finishes, then the block parks.
    $display("[TB] enable gate and dropped EOS");
    fill_mem_random();
    lat = 3;
    applyStimulus(1'b1, 1'b1);
    idle(5);
    enable = 1'b0;
    idle(3);
    applyStimulus(1'b0, 1'b0);
    wait_drain(500);
    idle(5);
    applyStimulus(1'b0, 1'b0);
    idle(40);
    fill_mem_random();
    applyStimulus(1'b1, 1'b1);
    wait_drain(500);

    // EOS during a pass with enable high: no extra pass.
    fill_mem_random();
    lat = 3;
    applyStimulus(1'b1, 1'b1);
    idle(6);
    applyStimulus(1'b1, 1'b0);
    wait_drain(500);
    idle(40);
    checkOutput("scan_cnt_no_extra", 128'(scan_cnt), 128'(cnt_m));

    // Reset while the third read of a pass is outstanding.
    $display("[TB] reset mid-read");
    fill_mem_random();
    lat = 5;
    applyStimulus(1'b1, 1'b1);
    dens = 0;
    for (int k = 0; k < 500 && dens < 3; k++) begin
      @(negedge clock);
      if (den) dens++;
    end
    checkOutput("reached_third_read", 128'(dens), 128'(3));
    mem[7'h40] = 16'($urandom);
    reset_dut();
    wait_drain(300);
    idle(20);
    fill_mem_random();
    applyStimulus(1'b1, 1'b1);
    wait_drain(500);
    checkOutput("scan_cnt_after_reset", 128'(scan_cnt), 128'(1));
    checkOutput("err_after_reset", 128'(err), 128'(0));

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
